gate_response_checker: RTL and testbench
========================================

Name: gate_response_checker

Overview:
- Synthesizable response checker for a single two-input gate under test; the receiving end of the gate stimulus sequence.
- Watches the gate inputs, waits a programmable settle time after each input change, then compares the gate output against the expected truth-table value.
- Accumulates vector and error counts, captures the first failing vector, and tracks input-combination coverage.
- Sits beside the gate under test; a stimulus source drives the gate, and this block produces the pass/fail summary.

Parameters:
- SETTLE_CYCLES, 2, clk cycles an input pair must hold stable before out_o is sampled; legal range is 1 to 255.
- CNT_W, 16, width of the vector, error and index counters.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle pulse that clears all results and begins checking.
- stop  input  1  single-cycle pulse that ends checking.
- func_sel  input  3  expected function: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR; 6 and 7 are treated as AND.
- in_a  input  1  gate input A, as driven to the gate under test.
- in_b  input  1  gate input B.
- out_o  input  1  gate output under test.
- busy  output  1  high in the SETTLE, CHECK and MONITOR states.
- done  output  1  high in the DONE state.
- pass  output  1  valid when done is high; pass = (err_count==0) && (vec_count!=0).
- vec_count  output  CNT_W  number of vectors checked; saturates at all-ones.
- err_count  output  CNT_W  number of mismatching vectors; saturates at all-ones.
- first_err_valid  output  1  a mismatch has been captured since the last start.
- first_err_vec  output  3  {a,b,o} of the first mismatching vector.
- first_err_idx  output  CNT_W  value of vec_count before the increment for the first mismatch; the first checked vector is index 0.
- coverage  output  4  bit {a,b} is set once that input combination has been checked.
- all_covered  output  1  equals &coverage.

Behaviour:
- Reset: every output, counter and register goes to 0, and the FSM enters IDLE. Reset asserted mid-run aborts the run immediately with no partial result held.
- FSM states: IDLE, SETTLE, CHECK, MONITOR, DONE.
- IDLE:
  - start: clear all results, latch func_sel into fsel_q, latch {in_a,in_b} into prev_ab, load settle_cnt = SETTLE_CYCLES-1, go to SETTLE.
  - stop in IDLE is ignored.
- SETTLE:
  - If {in_a,in_b} != prev_ab: update prev_ab, reload settle_cnt = SETTLE_CYCLES-1, stay in SETTLE. This filters glitches.
  - Else if settle_cnt==0: go to CHECK.
  - Else: decrement settle_cnt.
- CHECK (exactly one cycle):
  - expected = f(fsel_q, prev_a, prev_b).
  - Increment vec_count; set coverage[prev_ab].
  - If out_o != expected: increment err_count. If first_err_valid==0, capture first_err_vec = {prev_ab, out_o} and first_err_idx = old vec_count, then set first_err_valid.
  - Next state is MONITOR.
- MONITOR: on {in_a,in_b} != prev_ab, latch the new value into prev_ab, load settle_cnt, go to SETTLE. An unchanged pair is never re-checked.
- stop in SETTLE or MONITOR: go to DONE next cycle. The vector in SETTLE is discarded uncounted.
- stop in CHECK: the check completes and is counted, then go to DONE.
- start in any state other than IDLE: restart exactly as from IDLE. start takes priority over stop when both are asserted in the same cycle.
- DONE: results and pass are held. start restarts the run; stop is ignored.
- Latency: a stable input pair is counted SETTLE_CYCLES+1 cycles after the change edge. vec_count updates on the clock edge that ends CHECK.
- Counters saturate and never wrap. func_sel changes while running have no effect until the next start.

Test Plan:
- AND, SETTLE_CYCLES=2, correct gate; drive ab=00,10,10,11,01,00, each held for 4 cycles, then stop.
  -> vec_count=5 (the repeated 10 is not recounted), err_count=0, coverage=4'b1111, all_covered=1, done=1, pass=1.
- AND selected, gate replaced by OR; drive 00,01,10,11.
  -> err_count=2, first_err_vec=3'b011, first_err_idx=1, pass=0.
- Glitch: ab toggles 00->01->00 within 1 cycle, then holds 01.
  -> exactly one 01 vector is counted, no error, and the count occurs SETTLE_CYCLES+1 cycles after the last change.
- stop during SETTLE, 1 cycle after an input change.
  -> that vector is uncounted (vec_count unchanged), done=1 next cycle, busy=0.
- rst_n pulsed low mid-run after 3 vectors.
  -> all outputs read 0 asynchronously and the FSM is in IDLE; start then runs a clean, fresh count.
- CNT_W=2 with 5 distinct vector changes, all failing (NAND selected, AND gate).
  -> vec_count=3 and err_count=3 (both saturate), first_err_idx=0.

Source files
------------

// File: rtl/gate_response_checker.sv
// Response checker for one two-input gate: waits for each input pair to settle,
// compares the gate output to the selected truth table and keeps a pass/fail summary.
module gate_response_checker #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic [2:0]       func_sel,
  input  logic             in_a,
  input  logic             in_b,
  input  logic             out_o,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] vec_count,
  output logic [CNT_W-1:0] err_count,
  output logic             first_err_valid,
  output logic [2:0]       first_err_vec,
  output logic [CNT_W-1:0] first_err_idx,
  output logic [3:0]       coverage,
  output logic             all_covered
);

  localparam int unsigned    SW            = 8;
  localparam logic [SW-1:0]  SETTLE_RELOAD = SW'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETTLE  = 3'd1,
    S_CHECK   = 3'd2,
    S_MONITOR = 3'd3,
    S_DONE    = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        prev_ab_q, prev_ab_d;
  logic [2:0]        fsel_q, fsel_d;
  logic [SW-1:0]     settle_cnt_q, settle_cnt_d;
  logic [CNT_W-1:0]  vec_q, vec_d, err_q, err_d, fe_idx_q, fe_idx_d;
  logic              fe_valid_q, fe_valid_d;
  logic [2:0]        fe_vec_q, fe_vec_d;
  logic [3:0]        cov_q, cov_d;
  logic              busy_q, busy_d, done_q, done_d, pass_q, pass_d, allcov_q, allcov_d;
  logic [1:0]        ab_c;
  logic              expected_c;

  function automatic logic gate_fn(input logic [2:0] sel, input logic a, input logic b);
    case (sel)
      3'd1:    gate_fn = a | b;
      3'd2:    gate_fn = a ^ b;
      3'd3:    gate_fn = ~(a & b);
      3'd4:    gate_fn = ~(a | b);
      3'd5:    gate_fn = ~(a ^ b);
      default: gate_fn = a & b;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    sat_inc = (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  assign ab_c       = {in_a, in_b};
  assign expected_c = gate_fn(fsel_q, prev_ab_q[1], prev_ab_q[0]);

  // Next-state, result update and registered-output precompute
  always_comb begin
    state_d      = state_q;
    prev_ab_d    = prev_ab_q;
    fsel_d       = fsel_q;
    settle_cnt_d = settle_cnt_q;
    vec_d        = vec_q;
    err_d        = err_q;
    fe_valid_d   = fe_valid_q;
    fe_vec_d     = fe_vec_q;
    fe_idx_d     = fe_idx_q;
    cov_d        = cov_q;

    if (start) begin
      state_d      = S_SETTLE;
      fsel_d       = func_sel;
      prev_ab_d    = ab_c;
      settle_cnt_d = SETTLE_RELOAD;
      vec_d        = '0;
      err_d        = '0;
      fe_valid_d   = 1'b0;
      fe_vec_d     = '0;
      fe_idx_d     = '0;
      cov_d        = '0;
    end else begin
      case (state_q)
        S_SETTLE: begin
          if (stop) begin
            state_d = S_DONE;
          end else if (ab_c != prev_ab_q) begin
            prev_ab_d    = ab_c;
            settle_cnt_d = SETTLE_RELOAD;
          end else if (settle_cnt_q == '0) begin
            state_d = S_CHECK;
          end else begin
            settle_cnt_d = settle_cnt_q - SW'(1);
          end
        end
        S_CHECK: begin
          vec_d             = sat_inc(vec_q);
          cov_d[prev_ab_q]  = 1'b1;
          if (out_o != expected_c) begin
            err_d = sat_inc(err_q);
            if (!fe_valid_q) begin
              fe_valid_d = 1'b1;
              fe_vec_d   = {prev_ab_q, out_o};
              fe_idx_d   = vec_q;
            end
          end
          state_d = stop ? S_DONE : S_MONITOR;
        end
        S_MONITOR: begin
          if (stop) begin
            state_d = S_DONE;
          end else if (ab_c != prev_ab_q) begin
            prev_ab_d    = ab_c;
            settle_cnt_d = SETTLE_RELOAD;
            state_d      = S_SETTLE;
          end
        end
        default: ;
      endcase
    end

    busy_d   = (state_d == S_SETTLE) || (state_d == S_CHECK) || (state_d == S_MONITOR);
    done_d   = (state_d == S_DONE);
    pass_d   = (err_d == '0) && (vec_d != '0);
    allcov_d = &cov_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      prev_ab_q    <= '0;
      fsel_q       <= '0;
      settle_cnt_q <= '0;
      vec_q        <= '0;
      err_q        <= '0;
      fe_valid_q   <= 1'b0;
      fe_vec_q     <= '0;
      fe_idx_q     <= '0;
      cov_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      allcov_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      prev_ab_q    <= prev_ab_d;
      fsel_q       <= fsel_d;
      settle_cnt_q <= settle_cnt_d;
      vec_q        <= vec_d;
      err_q        <= err_d;
      fe_valid_q   <= fe_valid_d;
      fe_vec_q     <= fe_vec_d;
      fe_idx_q     <= fe_idx_d;
      cov_q        <= cov_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      allcov_q     <= allcov_d;
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign vec_count       = vec_q;
  assign err_count       = err_q;
  assign first_err_valid = fe_valid_q;
  assign first_err_vec   = fe_vec_q;
  assign first_err_idx   = fe_idx_q;
  assign coverage        = cov_q;
  assign all_covered     = allcov_q;

endmodule

// File: tb/tb_gate_response_checker.sv
// Directed bench for gate_response_checker: default instance plus a CNT_W=2 instance
// for counter saturation; the gates under test are modelled in the bench.
module tb_gate_response_checker;

  logic clk, rst_n;
  logic start, stop, start2, stop2;
  logic [2:0] func_sel;
  logic in_a, in_b;
  logic gate_kind;
  logic gate_out, gate_out2;

  logic        busy, done, pass, fev, allcov;
  logic [15:0] vec, err, feidx;
  logic [2:0]  fevec;
  logic [3:0]  cov;

  logic        busy2, done2, pass2, fev2, allcov2;
  logic [1:0]  vec2, err2, feidx2;
  logic [2:0]  fevec2;
  logic [3:0]  cov2;

  int n_cmp = 0;
  int n_err = 0;

  assign gate_out  = gate_kind ? (in_a | in_b) : (in_a & in_b);
  assign gate_out2 = in_a & in_b;

  gate_response_checker #(.SETTLE_CYCLES(2), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .func_sel(func_sel),
    .in_a(in_a), .in_b(in_b), .out_o(gate_out),
    .busy(busy), .done(done), .pass(pass), .vec_count(vec), .err_count(err),
    .first_err_valid(fev), .first_err_vec(fevec), .first_err_idx(feidx),
    .coverage(cov), .all_covered(allcov)
  );

  gate_response_checker #(.SETTLE_CYCLES(2), .CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(start2), .stop(stop2), .func_sel(3'd3),
    .in_a(in_a), .in_b(in_b), .out_o(gate_out2),
    .busy(busy2), .done(done2), .pass(pass2), .vec_count(vec2), .err_count(err2),
    .first_err_valid(fev2), .first_err_vec(fevec2), .first_err_idx(feidx2),
    .coverage(cov2), .all_covered(allcov2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_ab(input logic [1:0] ab);
    in_a = ab[1];
    in_b = ab[0];
  endtask

  task automatic pulse_start(input logic [2:0] fs, input logic [1:0] ab);
    func_sel = fs;
    set_ab(ab);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(3);
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1; start = 1'b0; stop = 1'b0; start2 = 1'b0; stop2 = 1'b0;
    func_sel = 3'd0; in_a = 1'b0; in_b = 1'b0; gate_kind = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_vec",  32'(vec),  32'd0);
    chk("rst_cov",  32'(cov),  32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    tick(1);

    // Correct AND gate, repeated pair not recounted, full coverage
    pulse_start(3'd0, 2'b00);
    chk("t1_vec00", 32'(vec), 32'd1);
    chk("t1_busy",  32'(busy), 32'd1);
    set_ab(2'b10); tick(4);
    set_ab(2'b10); tick(4);
    chk("t1_vec_rep", 32'(vec), 32'd2);
    set_ab(2'b11); tick(3);
    chk("t1_lat_before", 32'(vec), 32'd2);
    tick(1);
    chk("t1_lat_at", 32'(vec), 32'd3);
    set_ab(2'b01); tick(4);
    set_ab(2'b00); tick(4);
    pulse_stop();
    chk("t1_done",   32'(done),   32'd1);
    chk("t1_busy0",  32'(busy),   32'd0);
    chk("t1_vec",    32'(vec),    32'd5);
    chk("t1_err",    32'(err),    32'd0);
    chk("t1_cov",    32'(cov),    32'hF);
    chk("t1_allcov", 32'(allcov), 32'd1);
    chk("t1_pass",   32'(pass),   32'd1);
    chk("t1_fev",    32'(fev),    32'd0);

    // AND expected, OR gate: 01 and 10 mismatch
    gate_kind = 1'b1;
    pulse_start(3'd0, 2'b00);
    chk("t2_restart_vec", 32'(vec), 32'd1);
    set_ab(2'b01); tick(4);
    set_ab(2'b10); tick(4);
    set_ab(2'b11); tick(4);
    pulse_stop();
    chk("t2_vec",   32'(vec),   32'd4);
    chk("t2_err",   32'(err),   32'd2);
    chk("t2_fev",   32'(fev),   32'd1);
    chk("t2_fevec", 32'(fevec), 32'b011);
    chk("t2_feidx", 32'(feidx), 32'd1);
    chk("t2_pass",  32'(pass),  32'd0);
    chk("t2_done",  32'(done),  32'd1);
    gate_kind = 1'b0;

    // Glitch 01->00->01 counted once, SETTLE_CYCLES+1 after last change
    pulse_start(3'd0, 2'b00);
    set_ab(2'b01); tick(1);
    set_ab(2'b00); tick(1);
    set_ab(2'b01); tick(1);
    tick(2);
    chk("t3_vec_before", 32'(vec), 32'd1);
    tick(1);
    chk("t3_vec_at", 32'(vec), 32'd2);
    chk("t3_err",    32'(err), 32'd0);
    chk("t3_cov",    32'(cov), 32'b0011);

    // stop during SETTLE discards the pending vector
    set_ab(2'b11); tick(1);
    tick(1);
    pulse_stop();
    chk("t4_vec",  32'(vec),  32'd2);
    chk("t4_done", 32'(done), 32'd1);
    chk("t4_busy", 32'(busy), 32'd0);
    chk("t4_cov",  32'(cov),  32'b0011);

    // Asynchronous reset mid-run, then clean restart
    pulse_start(3'd0, 2'b00);
    set_ab(2'b10); tick(4);
    set_ab(2'b11); tick(4);
    chk("t5_vec3", 32'(vec), 32'd3);
    rst_n = 1'b0;
    #2;
    chk("t5_rst_vec",  32'(vec),  32'd0);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    chk("t5_rst_cov",  32'(cov),  32'd0);
    chk("t5_rst_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    tick(1);
    chk("t5_idle_busy", 32'(busy), 32'd0);
    pulse_start(3'd0, 2'b01);
    chk("t5_new_vec", 32'(vec), 32'd1);
    chk("t5_new_cov", 32'(cov), 32'b0010);
    chk("t5_new_err", 32'(err), 32'd0);
    pulse_stop();

    // CNT_W=2: NAND expected, AND gate, five failing vectors
    set_ab(2'b00);
    start2 = 1'b1;
    tick(1);
    start2 = 1'b0;
    tick(3);
    set_ab(2'b01); tick(4);
    set_ab(2'b10); tick(4);
    set_ab(2'b11); tick(4);
    set_ab(2'b00); tick(4);
    stop2 = 1'b1;
    tick(1);
    stop2 = 1'b0;
    chk("t6_vec",   32'(vec2),   32'd3);
    chk("t6_err",   32'(err2),   32'd3);
    chk("t6_feidx", 32'(feidx2), 32'd0);
    chk("t6_fevec", 32'(fevec2), 32'b000);
    chk("t6_done",  32'(done2),  32'd1);
    chk("t6_pass",  32'(pass2),  32'd0);
    chk("t6_main_idle", 32'(vec), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
